// File: rtl/snake_dir_sched.sv
// Direction scheduler for the snake core: arbitrates button pulses,
// rejects illegal turns and releases one queued turn per game Tick.
module snake_dir_sched #(
  parameter int         DEPTH       = 2,
  parameter logic [1:0] DEFAULT_DIR = 2'b01
) (
  input  logic       Clk,
  input  logic       Reset,
  input  logic       Up,
  input  logic       Right,
  input  logic       Down,
  input  logic       Left,
  input  logic       Tick,
  input  logic       Enable,
  input  logic       Clear,
  output logic [1:0] Dir,
  output logic       Turned,
  output logic       Drop,
  output logic [2:0] Count
);

  localparam int PW = (DEPTH > 2) ? 2 : 1;

  logic [1:0]    r_fifo [DEPTH];
  logic [PW-1:0] r_wr;
  logic [PW-1:0] r_rd;
  logic [2:0]    r_cnt;
  logic [1:0]    r_dir;
  logic          r_turned;
  logic          r_drop;

  logic          w_any;
  logic          w_multi;
  logic [1:0]    w_win;
  logic [1:0]    w_ref;
  logic [PW-1:0] w_last;
  logic          w_full;
  logic          w_pop;
  logic          w_rej;
  logic          w_push;

  always_comb begin
    w_any   = Up | Right | Down | Left;
    w_multi = (Up & (Right | Down | Left)) |
              (Right & (Down | Left)) |
              (Down & Left);
    w_win   = 2'b11;
    if (Up)         w_win = 2'b00;
    else if (Right) w_win = 2'b01;
    else if (Down)  w_win = 2'b10;
    w_last  = r_wr - PW'(1);
    // Turns are judged against the newest queued heading, not the live one
    w_ref   = (r_cnt != 3'd0) ? r_fifo[w_last] : r_dir;
    w_full  = (r_cnt == 3'(DEPTH));
    w_pop   = Tick && (r_cnt != 3'd0);
    w_rej   = (w_win == w_ref) ||
              (w_win == (w_ref ^ 2'b10)) ||
              (w_full && !Tick);
    w_push  = w_any && !w_rej;
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      for (int i = 0; i < DEPTH; i++) r_fifo[i] <= DEFAULT_DIR;
      r_wr     <= '0;
      r_rd     <= '0;
      r_cnt    <= 3'd0;
      r_dir    <= DEFAULT_DIR;
      r_turned <= 1'b0;
      r_drop   <= 1'b0;
    end else if (Clear) begin
      r_wr     <= '0;
      r_rd     <= '0;
      r_cnt    <= 3'd0;
      r_dir    <= DEFAULT_DIR;
      r_turned <= 1'b0;
      r_drop   <= 1'b0;
    end else if (!Enable) begin
      r_turned <= 1'b0;
      r_drop   <= 1'b0;
    end else begin
      r_turned <= w_pop;
      r_drop   <= w_multi | (w_any & w_rej);
      if (w_pop) begin
        r_dir <= r_fifo[r_rd];
        r_rd  <= r_rd + PW'(1);
      end
      if (w_push) begin
        r_fifo[r_wr] <= w_win;
        r_wr         <= r_wr + PW'(1);
      end
      r_cnt <= r_cnt + 3'(w_push) - 3'(w_pop);
    end
  end

  assign Dir    = r_dir;
  assign Turned = r_turned;
  assign Drop   = r_drop;
  assign Count  = r_cnt;

endmodule

// File: tb/tb_snake_dir_sched.sv
// Scoreboard bench for snake_dir_sched: queue-based heading model,
// directed scenarios followed by randomized presses and ticks.
module tb_snake_dir_sched;

  localparam int         DEPTH = 2;
  localparam logic [1:0] DEF   = 2'b01;

  logic       Clk    = 1'b0;
  logic       Reset  = 1'b1;
  logic       Up     = 1'b0;
  logic       Right  = 1'b0;
  logic       Down   = 1'b0;
  logic       Left   = 1'b0;
  logic       Tick   = 1'b0;
  logic       Enable = 1'b1;
  logic       Clear  = 1'b0;
  logic [1:0] Dir;
  logic       Turned;
  logic       Drop;
  logic [2:0] Count;

  snake_dir_sched #(.DEPTH(DEPTH), .DEFAULT_DIR(DEF)) dut (
    .Clk(Clk), .Reset(Reset),
    .Up(Up), .Right(Right), .Down(Down), .Left(Left),
    .Tick(Tick), .Enable(Enable), .Clear(Clear),
    .Dir(Dir), .Turned(Turned), .Drop(Drop), .Count(Count)
  );

  always #5 Clk = ~Clk;

  typedef struct packed {
    logic [1:0] dir;
    logic       turned;
    logic       drop;
    logic [2:0] cnt;
  } exp_t;

  exp_t       sb[$];
  logic [1:0] mq[$];
  logic [1:0] mdir;
  int         n_cmp = 0;
  int         n_bad = 0;
  bit         done  = 0;

  task automatic chk(string nm, exp_t act, exp_t exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s t=%0t: got dir=%b turned=%b drop=%b cnt=%0d, want dir=%b turned=%b drop=%b cnt=%0d",
               nm, $time, act.dir, act.turned, act.drop, act.cnt,
               exp.dir, exp.turned, exp.drop, exp.cnt);
    end
  endtask

  // Monitor: every cycle after the edge, pop and compare the expected outputs
  initial begin
    exp_t e;
    forever begin
      @(posedge Clk);
      #1;
      if (!Reset && sb.size() > 0) begin
        e = sb.pop_front();
        chk("cycle", {Dir, Turned, Drop, Count}, e);
      end
    end
  end

  task automatic step(bit u, bit r, bit d, bit l, bit t, bit en, bit clr);
    logic [3:0] p;
    logic [1:0] w, rf;
    int         n;
    bit         rej;
    exp_t       e;
    @(negedge Clk);
    Up = u; Right = r; Down = d; Left = l;
    Tick = t; Enable = en; Clear = clr;
    e.turned = 1'b0;
    e.drop   = 1'b0;
    if (clr) begin
      mq.delete();
      mdir = DEF;
    end else if (en) begin
      p = {u, r, d, l};
      n = u + r + d + l;
      if (n > 0) begin
        w = 2'b11;
        for (int k = 0; k < 4; k++)
          if (p[3-k]) begin w = 2'(k); break; end
        rf  = (mq.size() > 0) ? mq[$] : mdir;
        rej = (w == rf) || (w == (rf ^ 2'b10)) ||
              (mq.size() == DEPTH && !t);
        e.drop = (n > 1) || rej;
      end else begin
        rej = 1'b1;
        w   = 2'b00;
      end
      if (t && mq.size() > 0) begin
        mdir     = mq.pop_front();
        e.turned = 1'b1;
      end
      if (n > 0 && !rej) mq.push_back(w);
    end
    e.dir = mdir;
    e.cnt = 3'(mq.size());
    sb.push_back(e);
  endtask

  task automatic idle(int k);
    repeat (k) step(0, 0, 0, 0, 0, 1, 0);
  endtask

  task automatic tick();
    step(0, 0, 0, 0, 1, 1, 0);
  endtask

  // Reset raised between edges while Tick is high must clear outputs at once
  task automatic async_reset();
    @(negedge Clk);
    Up = 0; Right = 0; Down = 0; Left = 0; Clear = 0; Enable = 1;
    Tick  = 1;
    Reset = 1;
    #1;
    chk("async_reset", {Dir, Turned, Drop, Count}, {DEF, 1'b0, 1'b0, 3'd0});
    mq.delete();
    mdir = DEF;
    @(negedge Clk);
    Reset = 0;
    Tick  = 0;
  endtask

  initial begin
    int   bound;
    logic [3:0] pb;
    int   sel;
    mdir = DEF;
    #12;
    chk("reset", {Dir, Turned, Drop, Count}, {DEF, 1'b0, 1'b0, 3'd0});
    @(negedge Clk);
    Reset = 0;

    tick(); tick();
    step(1, 0, 0, 0, 0, 1, 0);
    idle(4);
    tick();
    idle(1);

    step(0, 0, 0, 0, 0, 1, 1);
    step(0, 0, 0, 1, 0, 1, 0);
    step(0, 1, 0, 0, 0, 1, 0);
    idle(1);

    step(1, 0, 0, 0, 0, 1, 0);
    step(0, 0, 0, 1, 0, 1, 0);
    step(0, 0, 1, 0, 0, 1, 0);
    tick(); tick(); tick();

    step(0, 0, 0, 0, 0, 1, 1);
    step(1, 0, 0, 1, 0, 1, 0);
    step(0, 0, 0, 1, 0, 1, 0);
    step(0, 0, 1, 0, 1, 1, 0);
    idle(1);

    step(0, 0, 0, 0, 1, 0, 0);
    step(0, 1, 0, 0, 1, 0, 0);
    idle(1);
    step(0, 0, 0, 0, 0, 1, 1);
    idle(1);
    step(1, 0, 0, 0, 0, 1, 0);
    async_reset();
    idle(2);

    for (int i = 0; i < 3000; i++) begin
      sel = $urandom_range(0, 9);
      if (sel < 3)      pb = 4'b0001 << $urandom_range(0, 3);
      else if (sel < 4) pb = 4'($urandom_range(1, 15));
      else              pb = 4'b0000;
      if ($urandom_range(0, 499) == 0) begin
        async_reset();
      end else begin
        step(pb[3], pb[2], pb[1], pb[0],
             $urandom_range(0, 3) == 0,
             $urandom_range(0, 15) != 0,
             $urandom_range(0, 99) == 0);
      end
    end

    bound = 0;
    while (sb.size() > 0 && bound < 10) begin
      @(posedge Clk);
      bound++;
    end
    #2;
    n_cmp++;
    if (sb.size() > 0) begin
      n_bad++;
      $display("FAIL drain: %0d expectations left, wanted 0", sb.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/snake_dir_sched.md
Name: snake_dir_sched

Overview:
- Schedules player direction commands into the snake game core.
- Inputs are debounced single-cycle button pulses (Left/Right/Up/Down SCEN strobes). The block arbitrates pulses that arrive in the same cycle and rejects illegal turns (180° reversal or repeat of the current heading).
- Accepted turns are buffered in a small FIFO. One turn is released per game step Tick, so fast multi-button input such as Up-then-Left within one step is not lost.
- Sits between the debouncers and snake_core. It runs on the board clock; Tick is a one-cycle strobe derived from the game-rate divider.

Parameters:
DEPTH, 2, turn FIFO depth; legal values 2 or 4
DEFAULT_DIR, 2'b01, heading loaded at reset and on Clear (encoding: 00 Up, 01 Right, 10 Down, 11 Left)

Ports:
Clk  in  1  board clock
Reset  in  1  asynchronous, active-high reset
Up  in  1  single-cycle debounced press pulse
Right  in  1  single-cycle debounced press pulse
Down  in  1  single-cycle debounced press pulse
Left  in  1  single-cycle debounced press pulse
Tick  in  1  one-cycle game step strobe
Enable  in  1  1 = game running; 0 = ignore presses and Tick
Clear  in  1  synchronous flush and reload of DEFAULT_DIR
Dir  out  2  heading applied to the current game step
Turned  out  1  one-cycle pulse: Dir changed on this Tick
Drop  out  1  one-cycle pulse: a press was discarded
Count  out  3  number of queued turns, 0..DEPTH

Behaviour:
- Interface: one clock (Clk). Reset is asynchronous and active-high.
- Reset values: Dir=DEFAULT_DIR, FIFO empty, Count=0, Turned=0, Drop=0.
- Priority per cycle: Clear > Enable low > normal operation.
- Clear=1: FIFO flushed, Count=0, Dir=DEFAULT_DIR, Turned=0, Drop=0. Presses and Tick that cycle are ignored.
- Enable=0: presses ignored with no Drop; Tick ignored; FIFO contents and Dir held.
- Arbitration: if several press pulses occur in one cycle, the winner is fixed priority Up > Right > Down > Left. Losers are discarded and Drop=1 the next cycle.
- Reference heading R = last enqueued entry if Count>0, else Dir. R is evaluated from pre-edge state.
- Rejection: winner W is rejected if W==R (duplicate) or W==R^2'b10 (reversal). Rejected press gives Drop=1 the next cycle.
- Full: if Count==DEPTH and Tick=0, W is rejected and Drop=1. If Count==DEPTH and Tick=1 in the same cycle, the pop frees a slot and W is accepted.
- Pop: on Tick with Count>0, the head is written to Dir at that edge and Turned=1 for the following cycle. With Count==0, Dir holds and Turned=0.
- Simultaneous push and pop: Count is unchanged; the pushed entry lands behind the remaining entries.
- Latency:
  - Press accepted at edge N is visible in Count after edge N.
  - Earliest reflection in Dir is at the next Tick edge.
  - With an empty FIFO and Tick coinciding with the press, the press is enqueued; it is not bypassed to Dir.
- Drop and Turned are registered and both may be high in the same cycle. Only one Drop pulse is issued per cycle regardless of how many causes apply.
- Pointers wrap modulo DEPTH. Count saturates logically at DEPTH; it never wraps.
- Reset asserted mid-operation returns all state to reset values immediately (asynchronously).

Test Plan:
- Reset with DEFAULT_DIR=01: Dir=01, Count=0, Turned=0, Drop=0. Tick pulses with no presses leave Dir=01 and Turned=0.
- Dir=01, Up pulse, then Tick 5 cycles later: Count becomes 1 after the press. On the Tick edge Dir=00 and Count=0; Turned=1 for one cycle.
- Dir=01: Left pulse → Drop=1 (reversal), Count=0. Right pulse → Drop=1 (duplicate), Count=0.
- Dir=01, Up then Left before any Tick: Count=2. First Tick gives Dir=00; second Tick gives Dir=11. A third press, Down, sent while Count=2 with no Tick → Drop=1.
- Up and Left pulses in the same cycle with Dir=01: Up is queued and Drop=1. Separately, with Count=2 (DEPTH=2), Down and Tick in the same cycle: pop occurs, Down is accepted, Count stays 2.
- Count=2: assert Enable=0 then pulse Tick → Dir and Count unchanged, no Drop. Pulse Clear → Count=0, Dir=DEFAULT_DIR. Assert Reset during a Tick → all outputs at reset values.
